// File: rtl/memory_fifo_sync.sv
// Single-clock FIFO over a 2-port array; read data registered, 1-cycle latency.
// Backpressure via full/empty: writes at full and reads at empty are dropped and flagged sticky.
module memory_fifo_sync #(
  parameter int DW        = 32,
  parameter int DEPTH     = 16,
  parameter int PROG_FULL = DEPTH - 2,
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          clear,
  input  logic          wr_en,
  input  logic [DW-1:0] din,
  input  logic          rd_en,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          full,
  output logic          prog_full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] PFULL_C = (AW+1)'(PROG_FULL);

  logic [DW-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [DW-1:0] dout_q;
  logic          dout_valid_q;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          wr_acc, rd_acc;

  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);
  assign prog_full = (count_q >= PFULL_C);

  assign wr_acc = wr_en & ~full & ~clear;
  assign rd_acc = rd_en & ~empty & ~clear;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (wr_en & full)  overflow_d  = 1'b1;
      if (rd_en & empty) underflow_d = 1'b1;
    end
  end

  // Storage is deliberately left unreset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      dout_valid_q <= rd_acc;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      if (rd_acc) dout_q <= mem[rd_ptr_q];
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule
